// File: rtl/arith_pkg.sv
// Shared widths and op-tag encodings for the arithmetic result path.
package arith_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int TAG_W_DEF  = 2;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_tag_e;

endpackage

// File: rtl/arith_result_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module arith_result_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    // No reset: contents are only observed after a write through the pointers.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/arith_result_buffer.sv
// Tagged result FIFO between single-cycle arithmetic units and a slow consumer.
// Optional RESULT_ACCUM_EN adds acc_sum, a running sum of popped data.
module arith_result_buffer
    import arith_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [TAG_W-1:0]              out_tag,
    output logic [$clog2(DEPTH):0]        count
`ifdef RESULT_ACCUM_EN
    ,
    output logic [DATA_W+3:0]             acc_sum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORD_W = DATA_W + TAG_W;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] rd_word;

    // Handshake flags come only from the registered count.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    arith_result_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_mem (
        .clk     (clk),
        .we      (push & ~flush),
        .wr_addr (wr_ptr),
        .wr_data ({in_tag, in_data}),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    assign {out_tag, out_data} = out_valid ? rd_word : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef RESULT_ACCUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum <= '0;
        end else if (flush) begin
            acc_sum <= '0;
        end else if (pop) begin
            acc_sum <= acc_sum + (DATA_W + 4)'(out_data);
        end
    end
`endif

endmodule

// File: tb/tb_arith_result_buffer.sv
// Self-checking bench for arith_result_buffer: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_arith_result_buffer;
    import arith_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [1:0]       in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [1:0]       out_tag;
    logic [CNT_W-1:0] count;
`ifdef RESULT_ACCUM_EN
    logic [11:0]      acc_sum;
`endif

    arith_result_buffer #(.DATA_W(8), .TAG_W(2), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .count     (count)
`ifdef RESULT_ACCUM_EN
        ,
        .acc_sum   (acc_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of {tag, data} words and an integer sum.
    logic [9:0]  q[$];
    int unsigned acc = 0;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [7:0] data;
        int         exp_count;
        logic       exp_ov;
        logic       exp_ir;
        logic [7:0] exp_od;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [9:0] head;
        head = (q.size() != 0) ? q[0] : 10'h000;
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("out_data", 32'(out_data), 32'(head[7:0]));
        chk("out_tag", 32'(out_tag), 32'(head[9:8]));
`ifdef RESULT_ACCUM_EN
        chk("acc_sum", 32'(acc_sum), acc);
`endif
    endtask

    // One clock: model is advanced from the inputs held across the edge.
    task automatic step();
        bit do_push;
        bit do_pop;
        do_pop  = out_ready && (q.size() != 0);
        do_push = in_valid && (q.size() != DEPTH);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
            acc = 0;
        end else begin
            if (do_pop) begin
                acc = (acc + 32'(q[0][7:0])) % 4096;
                void'(q.pop_front());
            end
            if (do_push) q.push_back({in_tag, in_data});
        end
        model_check();
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; out_ready = 0; in_data = 8'h00; in_tag = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        q.delete();
        acc = 0;
        model_check();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1;
        idle_inputs();
        //               iv ordy data  cnt ov ir od
        vecs[0] = '{1'b1, 1'b0, 8'h03, 1, 1'b1, 1'b1, 8'h03};
        vecs[1] = '{1'b1, 1'b0, 8'h05, 2, 1'b1, 1'b1, 8'h03};
        vecs[2] = '{1'b1, 1'b0, 8'h0F, 3, 1'b1, 1'b1, 8'h03};
        vecs[3] = '{1'b1, 1'b0, 8'h01, 4, 1'b1, 1'b0, 8'h03};
        vecs[4] = '{1'b1, 1'b0, 8'hAA, 4, 1'b1, 1'b0, 8'h03};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 3, 1'b1, 1'b1, 8'h05};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 1'b1, 8'h0F};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 1'b1, 8'h01};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h00};
        vecs[9] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h00};

        #2;
        do_reset();

        // Fill, refused fifth push, then drain in order.
        for (int i = 0; i < 10; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_data   = vecs[i].data;
            in_tag    = OP_SUB;
            step();
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
        end
        idle_inputs();

        // Concurrent push+pop at count=2 across pointer wrap.
        in_valid = 1; in_tag = OP_ADD;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        chk("conc.prefill", 32'(count), 32'd2);
        out_ready = 1;
        in_data = 8'h07;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("conc.count", 32'(count), 32'd2);
        end
        chk("conc.head", 32'(out_data), 32'h07);
        idle_inputs();
        step();

        // Full with simultaneous pop: slot only freed for the next cycle.
        in_valid = 1; in_tag = OP_MUL; in_data = 8'h40;
        step(); step();
        chk("full.count", 32'(count), 32'(DEPTH));
        out_ready = 1; in_data = 8'h41;
        step();
        chk("full.pop_only", 32'(count), 32'(DEPTH - 1));
        step();
        chk("full.refill", 32'(count), 32'(DEPTH - 1));
        idle_inputs();

        // Flush at count=3 with push and pop both offered.
        flush = 1; in_valid = 1; out_ready = 1; in_data = 8'h99;
        step();
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        idle_inputs();
        step();
        chk("flush.after", 32'(count), 32'd0);

        // Asynchronous reset while holding data.
        in_valid = 1; in_data = 8'h5A; in_tag = OP_DIV;
        step(); step();
        idle_inputs();
        do_reset();
        chk("rst.out_data", 32'(out_data), 32'd0);
        step();

`ifdef RESULT_ACCUM_EN
        // Twenty pops of FF wrap the 12-bit sum to 3EC.
        in_valid = 1; in_data = 8'hFF; in_tag = OP_ADD;
        step();
        out_ready = 1;
        for (int i = 0; i < 19; i++) step();
        in_valid = 0;
        step();
        chk("accum.sum", 32'(acc_sum), 32'h3EC);
        flush = 1;
        step();
        chk("accum.flush", 32'(acc_sum), 32'h0);
        idle_inputs();
`endif

        // Randomized traffic; data held stable while stalled.
        begin
            bit stalled = 0;
            for (int i = 0; i < 500; i++) begin
                if (!stalled) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = 8'($urandom);
                    in_tag   = 2'($urandom);
                end
                out_ready = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
                if (i >= 250) out_ready = 1'($urandom_range(0, 1));
                flush = ($urandom_range(0, 39) == 0);
                step();
                stalled = in_valid && !in_ready && !flush;
            end
        end
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
